forward_unit: RTL and testbench

- Pipeline data-forwarding control for the 5-stage, 16-register CPU.
- Compares the EX-stage source registers (ID/EX latch) against the destination registers of the instructions in MEM (EX/MEM latch) and WB (MEM/WB latch).
- Produces the ALU operand mux selects (forwarda, forwardb) and a MEM-to-MEM store-data forward select (forwardmm).
- Sits beside the EX/MEM datapath muxes; hazard and stall detection is handled elsewhere.

---
 rtl/forward_unit_pkg.sv | 13 +
 rtl/forward_unit_reg_match.sv | 15 +
 rtl/forward_unit.sv | 81 ++++++++
 tb/tb_forward_unit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/forward_unit_pkg.sv
// Shared CPU constants for the forwarding logic: register width, the
// operand-select encodings and the hardwired-zero register.
package forward_unit_pkg;

    localparam int REG_W = 4;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_MW = 2'b01;
    localparam logic [1:0] FWD_XM = 2'b10;

    localparam logic [REG_W-1:0] R0 = '0;

endpackage

// File: rtl/forward_unit_reg_match.sv
// Producer/consumer register match: true when an enabled producer writes a
// nonzero register that the consumer reads.
module reg_match #(
    parameter int REG_W = 4
) (
    input  logic             producer_we,
    input  logic [REG_W-1:0] producer_rd,
    input  logic [REG_W-1:0] consumer_rs,
    output logic             hit
);

    // R0 is hardwired to zero, so writes to it are never forwarded
    assign hit = producer_we && (producer_rd != '0) && (producer_rd == consumer_rs);

endmodule

// File: rtl/forward_unit.sv
// Forwarding control: selects ALU operand sources and MEM-to-MEM store data
// from the EX/MEM and MEM/WB producers, optionally registered.
module forward_unit
    import forward_unit_pkg::*;
#(
    parameter int REG_W   = forward_unit_pkg::REG_W,
    parameter bit REG_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             xm_regwrite,
    input  logic             mw_regwrite,
    input  logic             xm_memread,
    input  logic [REG_W-1:0] xm_rd,
    input  logic [REG_W-1:0] xm_rt,
    input  logic [REG_W-1:0] mw_rd,
    input  logic [REG_W-1:0] dx_rs,
    input  logic [REG_W-1:0] dx_rt,
    output logic [1:0]       forwarda,
    output logic [1:0]       forwardb,
    output logic             forwardmm
);

    logic       ex_we;
    logic       ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b, wb_hit_mm;
    logic [1:0] fwd_a_comb, fwd_b_comb;
    logic [1:0] fwd_a_q, fwd_b_q;
    logic       fwd_mm_q;

    // A load result is not ready in EX/MEM; the hazard unit stalls instead
    assign ex_we = xm_regwrite & ~xm_memread;

    reg_match #(.REG_W(REG_W)) u_ex_a (
        .producer_we (ex_we),       .producer_rd (xm_rd),
        .consumer_rs (dx_rs),       .hit         (ex_hit_a)
    );
    reg_match #(.REG_W(REG_W)) u_ex_b (
        .producer_we (ex_we),       .producer_rd (xm_rd),
        .consumer_rs (dx_rt),       .hit         (ex_hit_b)
    );
    reg_match #(.REG_W(REG_W)) u_wb_a (
        .producer_we (mw_regwrite), .producer_rd (mw_rd),
        .consumer_rs (dx_rs),       .hit         (wb_hit_a)
    );
    reg_match #(.REG_W(REG_W)) u_wb_b (
        .producer_we (mw_regwrite), .producer_rd (mw_rd),
        .consumer_rs (dx_rt),       .hit         (wb_hit_b)
    );
    reg_match #(.REG_W(REG_W)) u_wb_mm (
        .producer_we (mw_regwrite), .producer_rd (mw_rd),
        .consumer_rs (xm_rt),       .hit         (wb_hit_mm)
    );

    always_comb begin
        fwd_a_comb = FWD_RF;
        fwd_b_comb = FWD_RF;
        // EX/MEM is the youngest producer, so it wins over MEM/WB
        if (ex_hit_a)      fwd_a_comb = FWD_XM;
        else if (wb_hit_a) fwd_a_comb = FWD_MW;
        if (ex_hit_b)      fwd_b_comb = FWD_XM;
        else if (wb_hit_b) fwd_b_comb = FWD_MW;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_a_q  <= FWD_RF;
            fwd_b_q  <= FWD_RF;
            fwd_mm_q <= 1'b0;
        end else begin
            fwd_a_q  <= fwd_a_comb;
            fwd_b_q  <= fwd_b_comb;
            fwd_mm_q <= wb_hit_mm;
        end
    end

    // With REG_OUT=0 the flops have no load and are trimmed away
    assign forwarda  = REG_OUT ? fwd_a_q  : fwd_a_comb;
    assign forwardb  = REG_OUT ? fwd_b_q  : fwd_b_comb;
    assign forwardmm = REG_OUT ? fwd_mm_q : wb_hit_mm;

endmodule

// File: tb/tb_forward_unit.sv
// Scoreboard bench for forward_unit: a combinational and a registered
// instance share stimulus; a monitor pops expected selects and compares.
module tb_forward_unit;

    logic       clk;
    logic       rst;
    logic       xm_regwrite, mw_regwrite, xm_memread;
    logic [3:0] xm_rd, xm_rt, mw_rd, dx_rs, dx_rt;
    logic [1:0] fa_c, fb_c, fa_r, fb_r;
    logic       fmm_c, fmm_r;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        bit         regd;
        logic [1:0] a;
        logic [1:0] b;
        logic       mm;
    } exp_t;

    exp_t sb[$];
    event sb_ev;

    forward_unit #(.REG_W(4), .REG_OUT(1'b0)) dut_comb (
        .clk (clk), .rst (rst),
        .xm_regwrite (xm_regwrite), .mw_regwrite (mw_regwrite), .xm_memread (xm_memread),
        .xm_rd (xm_rd), .xm_rt (xm_rt), .mw_rd (mw_rd), .dx_rs (dx_rs), .dx_rt (dx_rt),
        .forwarda (fa_c), .forwardb (fb_c), .forwardmm (fmm_c)
    );

    forward_unit #(.REG_W(4), .REG_OUT(1'b1)) dut_reg (
        .clk (clk), .rst (rst),
        .xm_regwrite (xm_regwrite), .mw_regwrite (mw_regwrite), .xm_memread (xm_memread),
        .xm_rd (xm_rd), .xm_rt (xm_rt), .mw_rd (mw_rd), .dx_rs (dx_rs), .dx_rt (dx_rt),
        .forwarda (fa_r), .forwardb (fb_r), .forwardmm (fmm_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: drains the scoreboard whenever the driver posts an expectation
    initial begin
        exp_t       e;
        logic [1:0] aa, ab;
        logic       amm;
        forever begin
            @(sb_ev);
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                aa  = e.regd ? fa_r  : fa_c;
                ab  = e.regd ? fb_r  : fb_c;
                amm = e.regd ? fmm_r : fmm_c;
                checks++;
                if (aa !== e.a || ab !== e.b || amm !== e.mm) begin
                    failures++;
                    $display("FAIL %s: got a=%b b=%b mm=%b, expected a=%b b=%b mm=%b",
                             e.name, aa, ab, amm, e.a, e.b, e.mm);
                end
            end
        end
    end

    task automatic expect_now(input string nm, input bit regd,
                              input logic [1:0] ea, input logic [1:0] eb, input logic emm);
        exp_t e;
        e.name = nm; e.regd = regd; e.a = ea; e.b = eb; e.mm = emm;
        sb.push_back(e);
        -> sb_ev;
        #1;
    endtask

    task automatic drive(input logic xw, input logic mw, input logic mr,
                         input logic [3:0] xrd, input logic [3:0] xrt, input logic [3:0] mrd,
                         input logic [3:0] rs, input logic [3:0] rt);
        xm_regwrite = xw; mw_regwrite = mw; xm_memread = mr;
        xm_rd = xrd; xm_rt = xrt; mw_rd = mrd; dx_rs = rs; dx_rt = rt;
    endtask

    task automatic comb_vec(input string nm,
                            input logic xw, input logic mw, input logic mr,
                            input logic [3:0] xrd, input logic [3:0] xrt, input logic [3:0] mrd,
                            input logic [3:0] rs, input logic [3:0] rt,
                            input logic [1:0] ea, input logic [1:0] eb, input logic emm);
        drive(xw, mw, mr, xrd, xrt, mrd, rs, rt);
        #1;
        expect_now(nm, 1'b0, ea, eb, emm);
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        #2;
        expect_now("reset_state_reg", 1'b1, 2'b00, 2'b00, 1'b0);
        #9;
        rst = 1'b1;

        //        name             xw    mw    mr    xm_rd xm_rt mw_rd rs    rt     a      b      mm
        comb_vec("ex_fwd",        1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 2'b10, 2'b10, 1'b0);
        comb_vec("wb_fwd",        1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 2'b01, 2'b01, 1'b1);
        comb_vec("no_write",      1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 2'b00, 2'b00, 1'b0);
        comb_vec("ex_priority",   1'b1, 1'b1, 1'b0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 2'b10, 2'b10, 1'b1);
        comb_vec("load_fallthru", 1'b1, 1'b1, 1'b1, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 2'b01, 2'b01, 1'b1);
        comb_vec("r0_never",      1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0);
        comb_vec("split_a_ex_b_wb",1'b1, 1'b1, 1'b0, 4'd2, 4'd0, 4'd5, 4'd2, 4'd5, 2'b10, 2'b01, 1'b0);
        comb_vec("mm_only",       1'b0, 1'b1, 1'b1, 4'd3, 4'd7, 4'd7, 4'd1, 4'd2, 2'b00, 2'b00, 1'b1);
        comb_vec("ex_both_mm",    1'b1, 1'b1, 1'b0, 4'd4, 4'd9, 4'd9, 4'd4, 4'd4, 2'b10, 2'b10, 1'b1);
        comb_vec("ex_off_b_wb",   1'b0, 1'b1, 1'b0, 4'd6, 4'd0, 4'd8, 4'd6, 4'd8, 2'b00, 2'b01, 1'b0);
        comb_vec("load_no_wb",    1'b1, 1'b0, 1'b1, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 2'b00, 2'b00, 1'b0);

        // Registered instance: reset behaviour and one-cycle latency
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1);
        @(posedge clk);
        #1;
        expect_now("reg_load_wb", 1'b1, 2'b01, 2'b01, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        expect_now("reg_async_rst", 1'b1, 2'b00, 2'b00, 1'b0);
        rst = 1'b1;
        #1;
        expect_now("reg_rst_release_hold", 1'b1, 2'b00, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        expect_now("reg_after_release", 1'b1, 2'b01, 2'b01, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1);
        #1;
        expect_now("reg_latency_hold", 1'b1, 2'b01, 2'b01, 1'b1);
        @(posedge clk);
        #1;
        expect_now("reg_follow", 1'b1, 2'b10, 2'b10, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 4'd2, 4'd0, 4'd5, 4'd2, 4'd5);
        @(posedge clk);
        #1;
        expect_now("reg_split", 1'b1, 2'b10, 2'b01, 1'b0);

        #5;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
